// File: rtl/intc.sv
// Interrupt controller: synchronised sources, per-bit edge/level pending logic,
// enable mask, and an irq_out FSM that forces a low gap after each acknowledge.
module intc #(
  parameter logic [4:0] BASE_ADDR  = 5'h1c,
  parameter int         NUM_IRQS   = 8,
  parameter int         GAP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic [NUM_IRQS-1:0] irq_in,
  output logic                irq_out
);

  localparam logic [4:0] ADDR_EN   = BASE_ADDR;
  localparam logic [4:0] ADDR_PEND = BASE_ADDR + 5'd1;
  localparam logic [4:0] ADDR_EDGE = BASE_ADDR + 5'd2;
  localparam logic [4:0] ADDR_RAW  = BASE_ADDR + 5'd3;
  localparam logic [7:0] IRQ_MASK  = 8'((16'd1 << NUM_IRQS) - 16'd1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  logic [NUM_IRQS-1:0] sync_meta;
  logic [NUM_IRQS-1:0] sync;
  logic [NUM_IRQS-1:0] sync_d;

  logic [7:0] en_q;
  logic [7:0] edge_mode_q;
  logic [7:0] pend_q;
  logic [7:0] pend_nx;
  logic [7:0] raw;
  logic [7:0] rise;
  logic [7:0] w1c;

  logic wr_en;
  logic wr_pend;
  logic wr_edge;
  logic active;
  logic ack;

  state_t     state;
  state_t     state_nx;
  logic [3:0] gap_cnt;
  logic       irq_nx;

  function automatic logic [7:0] widen(input logic [NUM_IRQS-1:0] v);
    logic [7:0] r;
    r = '0;
    r[NUM_IRQS-1:0] = v;
    return r;
  endfunction

  // Stage: two-flop synchroniser plus one delay flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
      sync_d    <= '0;
    end else begin
      sync_meta <= irq_in;
      sync      <= sync_meta;
      sync_d    <= sync;
    end
  end

  assign raw     = widen(sync);
  assign rise    = raw & ~widen(sync_d);
  assign wr_en   = csr_we && (csr_a == ADDR_EN);
  assign wr_pend = csr_we && (csr_a == ADDR_PEND);
  assign wr_edge = csr_we && (csr_a == ADDR_EDGE);
  assign w1c     = wr_pend ? (csr_di & IRQ_MASK) : 8'h00;
  assign ack     = wr_pend && ((csr_di & IRQ_MASK) != 8'h00);

  // Edge bits latch a rise (beating a same-cycle clear); level bits track sync.
  always_comb begin
    pend_nx = IRQ_MASK & ((edge_mode_q & (rise | (pend_q & ~w1c))) |
                          (~edge_mode_q & raw));
  end

  // Stage: CSR registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 8'h00;
      edge_mode_q <= 8'h00;
      pend_q      <= 8'h00;
    end else begin
      pend_q <= pend_nx;
      if (wr_en) begin
        en_q <= csr_di & IRQ_MASK;
      end
      if (wr_edge) begin
        edge_mode_q <= csr_di & IRQ_MASK;
      end
    end
  end

  assign active = |(pend_q & en_q);

  always_comb begin
    case (csr_a)
      ADDR_EN:   csr_do = en_q;
      ADDR_PEND: csr_do = pend_q;
      ADDR_EDGE: csr_do = edge_mode_q;
      ADDR_RAW:  csr_do = raw;
      default:   csr_do = 8'h00;
    endcase
  end

  // Stage: output FSM state, gap counter and registered irq_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= 4'd0;
      irq_out <= 1'b0;
    end else begin
      state   <= state_nx;
      irq_out <= irq_nx;
      if ((state == ACTIVE) && (state_nx == GAP)) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == GAP) && (gap_cnt != 4'd0)) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (active) begin
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ack) begin
          state_nx = GAP;
        end else if (!active) begin
          state_nx = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          state_nx = active ? ACTIVE : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    irq_nx = (state_nx == ACTIVE);
  end

endmodule

// File: tb/tb_intc.sv
// Bench for intc: per-cycle comparison against a behavioural model of the
// 8-source default instance, plus directed literal checks on both instances.
module tb_intc;

  localparam logic [4:0] BASE   = 5'h1c;
  localparam logic [4:0] A_EN   = BASE;
  localparam logic [4:0] A_PEND = BASE + 5'd1;
  localparam logic [4:0] A_EDGE = BASE + 5'd2;
  localparam logic [4:0] A_RAW  = BASE + 5'd3;
  localparam logic [4:0] A_OUT  = BASE + 5'd4;
  localparam logic [4:0] BASE4  = 5'h10;
  localparam int         GAP    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;
  logic [7:0] irq_in;
  logic       irq_out;

  logic [4:0] csr_a4;
  logic [7:0] csr_di4;
  logic       csr_we4;
  logic [7:0] csr_do4;
  logic [3:0] irq_in4;
  logic       irq_out4;

  int compared   = 0;
  int mismatched = 0;

  always #10 clk = ~clk;

  intc #(.BASE_ADDR(BASE), .NUM_IRQS(8), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do), .irq_in(irq_in), .irq_out(irq_out)
  );

  intc #(.BASE_ADDR(BASE4), .NUM_IRQS(4), .GAP_CYCLES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .csr_a(csr_a4), .csr_di(csr_di4), .csr_we(csr_we4),
    .csr_do(csr_do4), .irq_in(irq_in4), .irq_out(irq_out4)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: inputs are seen through a 2-cycle synchroniser, so
  // h2 is "what the controller sees now" and h3 is "what it saw last cycle".
  logic [7:0] m_en = '0, m_edge = '0, m_pend = '0;
  logic [7:0] h1 = '0, h2 = '0, h3 = '0;
  logic       m_out = 1'b0;
  int         m_gap = 0;
  logic       m_act, m_ack, m_clr;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_en = '0; m_edge = '0; m_pend = '0;
      h1 = '0; h2 = '0; h3 = '0;
      m_out = 1'b0; m_gap = 0;
    end else begin
      m_act = |(m_pend & m_en);
      m_ack = csr_we && (csr_a == A_PEND) && (csr_di != 8'h00);
      if (m_gap > 0) begin
        m_gap--;
        m_out = (m_gap == 0) ? m_act : 1'b0;
      end else if (m_out && m_ack) begin
        m_gap = GAP;
        m_out = 1'b0;
      end else begin
        m_out = m_act;
      end
      for (int i = 0; i < 8; i++) begin
        m_clr = csr_we && (csr_a == A_PEND) && csr_di[i];
        if (!m_edge[i]) m_pend[i] = h2[i];
        else if (h2[i] && !h3[i]) m_pend[i] = 1'b1;
        else if (m_clr) m_pend[i] = 1'b0;
      end
      if (csr_we && csr_a == A_EN) m_en = csr_di;
      if (csr_we && csr_a == A_EDGE) m_edge = csr_di;
      h3 = h2; h2 = h1; h1 = irq_in;
    end
  end

  function automatic logic [7:0] m_read(input logic [4:0] a);
    if (a == A_EN) return m_en;
    if (a == A_PEND) return m_pend;
    if (a == A_EDGE) return m_edge;
    if (a == A_RAW) return h2;
    return 8'h00;
  endfunction

  always begin
    @(posedge clk);
    #1;
    chk("model_irq_out", {7'b0, irq_out}, {7'b0, m_out});
    chk("model_csr_do", csr_do, m_read(csr_a));
  end

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0; csr_a = A_PEND; csr_di = 8'h00;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [7:0] exp);
    @(negedge clk);
    csr_a = a;
    #1;
    chk(name, csr_do, exp);
    csr_a = A_PEND;
  endtask

  task automatic wr4(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    csr_a4 = a; csr_di4 = d; csr_we4 = 1'b1;
    @(negedge clk);
    csr_we4 = 1'b0; csr_di4 = 8'h00;
  endtask

  task automatic rd4(input string name, input logic [4:0] a, input logic [7:0] exp);
    @(negedge clk);
    csr_a4 = a;
    #1;
    chk(name, csr_do4, exp);
  endtask

  task automatic expect_out(input string name, input logic exp);
    @(posedge clk);
    #1;
    chk(name, {7'b0, irq_out}, {7'b0, exp});
  endtask

  initial begin
    rst_n = 1'b0; csr_a = A_PEND; csr_di = 8'h00; csr_we = 1'b0; irq_in = 8'h00;
    csr_a4 = BASE4; csr_di4 = 8'h00; csr_we4 = 1'b0; irq_in4 = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq_out", {7'b0, irq_out}, 8'h00);
    rd("rst_en", A_EN, 8'h00);
    rd("rst_edge", A_EDGE, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Edge mode on bit 0: 4-edge latency, then acknowledge
    wr(A_EN, 8'h01);
    wr(A_EDGE, 8'h01);
    @(negedge clk);
    irq_in[0] = 1'b1;
    for (int k = 0; k < 3; k++) expect_out("t1_latency_low", 1'b0);
    expect_out("t1_latency_high", 1'b1);
    rd("t1_pend", A_PEND, 8'h01);
    wr(A_PEND, 8'h01);
    chk("t1_ack_out", {7'b0, irq_out}, 8'h00);
    rd("t1_pend_clr", A_PEND, 8'h00);
    irq_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("t1_idle_out", {7'b0, irq_out}, 8'h00);

    // Two pending sources: ack one, output gaps for exactly GAP cycles
    wr(A_EN, 8'h03);
    wr(A_EDGE, 8'h03);
    @(negedge clk);
    irq_in[1:0] = 2'b11;
    repeat (5) @(negedge clk);
    rd("t2_pend", A_PEND, 8'h03);
    chk("t2_out_high", {7'b0, irq_out}, 8'h01);
    wr(A_PEND, 8'h01);
    chk("t2_gap_start", {7'b0, irq_out}, 8'h00);
    for (int k = 0; k < GAP - 1; k++) expect_out("t2_gap_low", 1'b0);
    expect_out("t2_gap_reassert", 1'b1);
    rd("t2_pend_left", A_PEND, 8'h02);
    wr(A_PEND, 8'h02);
    irq_in = 8'h00;
    repeat (8) @(negedge clk);
    chk("t2_idle_out", {7'b0, irq_out}, 8'h00);

    // Level mode on bit 2: clear has no lasting effect
    wr(A_EDGE, 8'h00);
    wr(A_EN, 8'h04);
    @(negedge clk);
    irq_in[2] = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_out_high", {7'b0, irq_out}, 8'h01);
    wr(A_PEND, 8'h04);
    chk("t3_gap_start", {7'b0, irq_out}, 8'h00);
    for (int k = 0; k < GAP - 1; k++) expect_out("t3_gap_low", 1'b0);
    expect_out("t3_gap_reassert", 1'b1);
    rd("t3_pend_level", A_PEND, 8'h04);
    @(negedge clk);
    irq_in[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t3_drop_out", {7'b0, irq_out}, 8'h00);

    // Edge set coincides with clear on bit 3; set regardless of EN
    wr(A_EN, 8'h00);
    wr(A_EDGE, 8'h08);
    @(negedge clk);
    irq_in[3] = 1'b1;
    @(negedge clk);
    wr(A_PEND, 8'h08);
    rd("t4_set_wins", A_PEND, 8'h08);
    chk("t4_out_disabled", {7'b0, irq_out}, 8'h00);
    wr(A_PEND, 8'h08);
    rd("t4_cleared", A_PEND, 8'h00);
    irq_in[3] = 1'b0;

    // Address decode outside the window
    wr(A_EN, 8'hff);
    rd("t5_base_plus4", A_OUT, 8'h00);
    rd("t5_addr0", 5'h00, 8'h00);
    rd("t5_addr1b", 5'h1b, 8'h00);
    rd("t5_en_ff", A_EN, 8'hff);
    wr(A_EN, 8'h00);

    // Four-source instance: masked bits, RAW, ack only below NUM_IRQS
    wr4(BASE4, 8'hff);
    rd4("t5_en4", BASE4, 8'h0f);
    wr4(BASE4 + 5'd2, 8'hff);
    rd4("t5_edge4", BASE4 + 5'd2, 8'h0f);
    irq_in4 = 4'hf;
    repeat (6) @(negedge clk);
    rd4("t5_raw4", BASE4 + 5'd3, 8'h0f);
    rd4("t5_pend4", BASE4 + 5'd1, 8'h0f);
    chk("t5_out4_high", {7'b0, irq_out4}, 8'h01);
    wr4(BASE4 + 5'd1, 8'hf0);
    @(negedge clk);
    chk("t5_no_ack_high", {7'b0, irq_out4}, 8'h01);
    rd4("t5_pend4_kept", BASE4 + 5'd1, 8'h0f);
    wr4(BASE4 + 5'd1, 8'h01);
    chk("t5_ack4_low", {7'b0, irq_out4}, 8'h00);
    rd4("t5_out_of_win4", BASE, 8'h00);

    // Reset mid-GAP, then a source already high is caught in edge mode
    wr(A_EN, 8'h01);
    wr(A_EDGE, 8'h01);
    @(negedge clk);
    irq_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_out_high", {7'b0, irq_out}, 8'h01);
    wr(A_PEND, 8'h01);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("t6_rst_out", {7'b0, irq_out}, 8'h00);
    csr_a = A_EN;   #1 chk("t6_rst_en", csr_do, 8'h00);
    csr_a = A_PEND; #1 chk("t6_rst_pend", csr_do, 8'h00);
    csr_a = A_EDGE; #1 chk("t6_rst_edge", csr_do, 8'h00);
    csr_a = A_RAW;  #1 chk("t6_rst_raw", csr_do, 8'h00);
    csr_a = A_PEND;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr(A_EDGE, 8'h01);
    repeat (3) @(negedge clk);
    rd("t6_pend_after_rst", A_PEND, 8'h01);
    chk("t6_out_disabled", {7'b0, irq_out}, 8'h00);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/intc.md
INTC -- requirements
Module: intc

Interface
REQ-001 Parameter BASE_ADDR, default 5'h1c: CSR word address of register 0; the block occupies BASE_ADDR..BASE_ADDR+3, and BASE_ADDR+3 SHALL NOT exceed 5'h1f.
REQ-002 Parameter NUM_IRQS, default 8, range 1..8: number of interrupt sources.
REQ-003 Parameter GAP_CYCLES, default 4, range 1..15: forced irq_out low time, in clk cycles, after an acknowledge.
REQ-004 clk  input  1  system clock; all state is on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 csr_a  input  5  CSR word address.
REQ-007 csr_di  input  8  CSR write data.
REQ-008 csr_we  input  1  CSR write strobe, one cycle per write.
REQ-009 csr_do  output  8  CSR read data; 8'h00 when csr_a is outside the block window (wired-OR bus).
REQ-010 irq_in  input  NUM_IRQS  asynchronous interrupt sources, active-high.
REQ-011 irq_out  output  1  registered, active-high interrupt to the host.

Function
REQ-012 Each irq_in bit SHALL pass through a 2-flop synchronizer (sync), followed by one delay flop (sync_d).
REQ-013 The block SHALL implement the following registers, bit i corresponding to source i:
- BASE+0 EN: read/write interrupt enable.
- BASE+1 PEND: read; write-1-to-clear.
- BASE+2 EDGE: read/write; 1 selects rising-edge mode, 0 selects level mode.
- BASE+3 RAW: read-only view of sync.
REQ-014 Bits at index NUM_IRQS and above SHALL read 0, and writes to them SHALL be ignored; writes to RAW SHALL be ignored.
REQ-015 csr_do SHALL be combinational from csr_a and the current register state (zero wait states).
REQ-016 A write SHALL take effect on the clk edge where csr_we=1 and csr_a matches the register address.
REQ-017 Edge-mode pending: PEND[i] SHALL set on the cycle where sync[i]=1 and sync_d[i]=0, and SHALL hold until cleared by W1C.
REQ-018 Edge-mode simultaneous event: when set and W1C coincide on the same bit, set SHALL win.
REQ-019 Level-mode pending: PEND[i] SHALL equal sync[i], registered each cycle; W1C SHALL have no lasting effect.
REQ-020 Writing EDGE SHALL NOT alter PEND directly; the next cycle follows the new mode's rule.
REQ-021 PEND SHALL be set regardless of EN.
REQ-022 The signal active SHALL be defined as |(PEND & EN).
REQ-023 The output FSM SHALL have states IDLE, ACTIVE and GAP; irq_out SHALL be 1 only in ACTIVE and SHALL be registered from the next state.
REQ-024 FSM transitions:
- IDLE -> ACTIVE when active=1.
- ACTIVE -> GAP on a PEND write that has at least one 1 in bits below NUM_IRQS ("ack").
- ACTIVE -> IDLE when active=0 and no ack.
- GAP: a 4-bit counter loads GAP_CYCLES-1 on entry and decrements; at 0 the FSM goes to ACTIVE if active=1, else to IDLE.
REQ-025 An ack received in GAP or IDLE SHALL NOT restart or extend the GAP count.
REQ-026 Consequently, with active remaining 1 across an ack, irq_out SHALL be low for exactly GAP_CYCLES cycles and then reassert (a fresh edge for edge-triggered hosts).
REQ-027 Latency: an irq_in rising edge with EN=1 in IDLE SHALL raise irq_out 4 clk edges later (2 sync + PEND + irq_out).

Reset
REQ-028 While rst_n=0, the following SHALL be reset asynchronously: EN=0, EDGE=0, PEND=0, sync=0, sync_d=0, FSM=IDLE, GAP counter=0, irq_out=0.
REQ-029 Reset asserted mid-GAP or mid-ACTIVE SHALL force irq_out=0 immediately.
REQ-030 After rst_n deasserts, a source already high SHALL set PEND in edge mode (sync_d=0 from reset).

Verification
REQ-031 Edge mode, EN=8'h01, EDGE=8'h01, irq_in[0] rises -> irq_out=1 after 4 cycles; PEND reads 8'h01; W1C 8'h01 -> irq_out=0, PEND=8'h00.
REQ-032 EN=8'h03, edge mode on bits 0 and 1, both pending, W1C 8'h01 -> irq_out low for exactly 4 cycles, then 1; PEND=8'h02.
REQ-033 Level mode on bit 2, irq_in[2] held high, W1C 8'h04 -> PEND[2] remains 1; irq_out goes through GAP and reasserts; irq_in[2] low -> irq_out=0 within 4 cycles.
REQ-034 Edge set and W1C on the same bit in the same cycle -> PEND bit remains 1.
REQ-035 Read of BASE+4 and of 5'h00 -> csr_do=8'h00; with NUM_IRQS=4, write EN=8'hff -> EN reads 8'h0f.
REQ-036 rst_n pulsed low during GAP -> irq_out=0 and all registers read 8'h00 immediately; with irq_in[0]=1 after reset and EDGE written to 8'h01, PEND[0] sets.
